timer_ctrl_master: RTL and testbench
====================================

# timer_ctrl_master

Avalon-MM initiator that programs and services the 16-bit-register interval timer peripheral in hardware, with no CPU involvement. Local logic issues CONFIG, STOP and SNAP commands over a valid/ready port. The block turns each command into the timer's register write/read sequence. It also services the timer interrupt by clearing the timeout status, then emits a tick pulse and a wrapping tick count.

## Interface
- TICK_W, 16, width of tick_count
- clk  in  1  system clock
- reset_n  in  1  reset reset_n, asynchronous, active-low; clock clk
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  0=CONFIG, 1=STOP, 2=SNAP, 3=NOP
- cmd_period  in  32  timer period (CONFIG)
- cmd_continuous  in  1  CONT bit (CONFIG)
- cmd_irq_en  in  1  ITO bit (CONFIG)
- done  out  1  one-cycle pulse, command finished
- resp_valid  out  1  one-cycle pulse, snapshot valid (SNAP only, same cycle as done)
- resp_data  out  32  snapshot value, held until the next SNAP completes
- tick  out  1  one-cycle pulse per serviced interrupt
- tick_count  out  TICK_W  serviced-interrupt count, wraps modulo 2^TICK_W
- av_address  out  3  timer register address
- av_chipselect  out  1  bus cycle active
- av_write_n  out  1  0=write, 1=read
- av_writedata  out  16  write data
- av_readdata  in  16  timer read data, registered by the timer (read latency 1, no waitrequest)
- timer_irq  in  1  timer interrupt, level

## Operation
- Register map: 0=STATUS (any write clears TO), 1=CONTROL {STOP[3],START[2],CONT[1],ITO[0]}, 2=PERIODL, 3=PERIODH, 4=SNAPL, 5=SNAPH (any write latches the snapshot).
- FSM states: IDLE, CFG_PL, CFG_PH, CFG_CTL, STOP_CTL, SNAP_WR, SNAP_RL, SNAP_RH, SNAP_CAP, IRQ_CLR.
- IDLE bus: chipselect=0, write_n=1, address=0, writedata=0.
- cmd_ready = (state==IDLE) && !timer_irq.
- Arbitration: in IDLE, timer_irq takes priority over a pending command.
- IRQ path: IDLE with timer_irq=1 -> IRQ_CLR (write addr0, data 0) -> IDLE, tick=1 and tick_count+1 in the cycle after IRQ_CLR.
- CONFIG sequence, then done:
  - CFG_PL: write addr2 with period[15:0].
  - CFG_PH: write addr3 with period[31:16].
  - CFG_CTL: write addr1 with {0,1,cont,irq_en}.
  - Operands are latched at acceptance.
- STOP: STOP_CTL writes addr1 with {1,0,cont_last,ien_last}, where cont_last/ien_last are the latched last-configured bits (reset 0); then done.
- SNAP sequence:
  - SNAP_WR: write addr4.
  - SNAP_RL: read addr4.
  - SNAP_RH: read addr5; capture av_readdata into low half.
  - SNAP_CAP: read addr5 held; capture av_readdata into high half.
  - Then done + resp_valid with resp_data = {high, low}.
- NOP: done pulse on the cycle after acceptance, no bus activity.
- A timeout arriving during the same cycle as an IRQ_CLR write is lost; the timer gives clear priority. This is documented behaviour, not a block defect.
- Reset values: cmd_ready=0 while reset_n=0, then 1 (if !timer_irq). done=0, resp_valid=0, resp_data=0, tick=0, tick_count=0, bus at IDLE values.
- Reset mid-sequence: FSM returns to IDLE immediately and the partial sequence is abandoned; no done is issued.

## Timing
- Bus outputs are registered from state; one state = one bus cycle.
- Acceptance at cycle 0:
  - CONFIG: writes in cycles 1-3, done in cycle 4.
  - STOP: write in cycle 1, done in cycle 2.
  - SNAP: SNAP_WR in cycle 1, captures in cycles 3 and 4, done/resp_valid in cycle 5.
  - NOP: done in cycle 1.
- IRQ latency: timer_irq high in IDLE at cycle 0 -> IRQ_CLR write in cycle 1 -> tick in cycle 2. The timer drops irq after the cycle-1 edge, so the FSM sees irq low in cycle 2 and there is no double service.
- Back-to-back: a new command may be accepted in the cycle done is high (FSM is in IDLE).

## Structure
- Package timer_ctrl_pkg holds: op encodings, register address constants (ADDR_STATUS..ADDR_SNAPH), CONTROL bit indices, and the state enum.
- Single module, no sub-modules; the FSM and datapath are flat.

## Test plan
- CONFIG with period=0x0001_86A0, cont=1, ien=1 -> writes (2,0x86A0), (3,0x0001), (1,0x7) in consecutive cycles; done in cycle 4.
- SNAP against a timer model with counter=0x0002_1234 -> bus sequence W4, R4, R5, R5; resp_data=0x0002_1234 with resp_valid in cycle 5.
- timer_irq asserted while idle -> single write (0,0x0000); tick one cycle; tick_count 0->1; cmd_ready low while irq is high.
- timer_irq and cmd_valid (STOP) in the same IDLE cycle -> IRQ_CLR first, then STOP writes (1,0xB) with the last cont=1/ien=1; one done.
- Force tick_count to 0xFFFF, trigger one interrupt -> tick_count becomes 0x0000.
- reset_n pulsed low during CFG_PH -> bus returns to IDLE values immediately; no done; next CONFIG completes normally.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: command encodings, timer register map and FSM states shared by the timer command master.
package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_CONFIG = 2'd0,
        OP_STOP   = 2'd1,
        OP_SNAP   = 2'd2,
        OP_NOP    = 2'd3
    } op_e;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;
    localparam logic [2:0] ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] ADDR_SNAPH   = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    typedef enum logic [3:0] {
        IDLE, CFG_PL, CFG_PH, CFG_CTL, STOP_CTL,
        SNAP_WR, SNAP_RL, SNAP_RH, SNAP_CAP, IRQ_CLR
    } state_e;

    function automatic logic [15:0] ctrl_word(input logic stop, input logic start,
                                              input logic cont, input logic ito);
        logic [15:0] w;
        w = '0;
        w[CTRL_STOP]  = stop;
        w[CTRL_START] = start;
        w[CTRL_CONT]  = cont;
        w[CTRL_ITO]   = ito;
        return w;
    endfunction

endpackage

// File: rtl/timer_ctrl_master_if.sv
// timer_ctrl_master_if: Avalon-MM register link and interrupt line between the command master and the interval timer.
interface timer_ctrl_master_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
    modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/timer_ctrl_master.sv
// timer_ctrl_master: turns CONFIG/STOP/SNAP commands into interval-timer register sequences and services its interrupt.
module timer_ctrl_master
    import timer_ctrl_pkg::*;
#(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [31:0]       cmd_period,
    input  logic              cmd_continuous,
    input  logic              cmd_irq_en,
    output logic              done,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    timer_ctrl_master_if.master av
);

    state_e            state_q, state_d;
    logic [31:0]       period_q, period_d;
    logic              cont_q, cont_d, ien_q, ien_d;
    logic [15:0]       snap_lo_q, snap_lo_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic              done_q, done_d, resp_valid_q, resp_valid_d, tick_q, tick_d;
    logic [TICK_W-1:0] tick_count_q, tick_count_d;
    logic [2:0]        addr_q, addr_d;
    logic              cs_q, cs_d, wn_q, wn_d;
    logic [15:0]       wd_q, wd_d;
    logic              accept;

    assign cmd_ready = reset_n && state_q == IDLE && !av.irq;
    assign accept    = cmd_valid && cmd_ready;

    // cont/ien latched on CONFIG double as the last-configured bits reused by STOP
    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        cont_d       = cont_q;
        ien_d        = ien_q;
        snap_lo_d    = snap_lo_q;
        resp_data_d  = resp_data_q;
        done_d       = 1'b0;
        resp_valid_d = 1'b0;
        tick_d       = 1'b0;
        tick_count_d = tick_count_q;
        case (state_q)
            IDLE: begin
                if (av.irq) begin
                    state_d = IRQ_CLR;
                end else if (accept) begin
                    state_d = cmd_op == OP_CONFIG ? CFG_PL :
                              cmd_op == OP_STOP   ? STOP_CTL :
                              cmd_op == OP_SNAP   ? SNAP_WR : IDLE;
                    done_d  = cmd_op == OP_NOP;
                    if (cmd_op == OP_CONFIG) begin
                        period_d = cmd_period;
                        cont_d   = cmd_continuous;
                        ien_d    = cmd_irq_en;
                    end
                end
            end
            CFG_PL:   state_d = CFG_PH;
            CFG_PH:   state_d = CFG_CTL;
            CFG_CTL:  begin state_d = IDLE; done_d = 1'b1; end
            STOP_CTL: begin state_d = IDLE; done_d = 1'b1; end
            SNAP_WR:  state_d = SNAP_RL;
            SNAP_RL:  state_d = SNAP_RH;
            SNAP_RH:  begin state_d = SNAP_CAP; snap_lo_d = av.readdata; end
            SNAP_CAP: begin
                state_d      = IDLE;
                resp_data_d  = {av.readdata, snap_lo_q};
                done_d       = 1'b1;
                resp_valid_d = 1'b1;
            end
            IRQ_CLR:  begin
                state_d      = IDLE;
                tick_d       = 1'b1;
                tick_count_d = tick_count_q + 1'b1;
            end
            default:  state_d = IDLE;
        endcase
    end

    // Bus signals are decoded from the next state so each state owns exactly its own bus cycle
    always_comb begin
        cs_d   = state_d != IDLE;
        wn_d   = !(state_d inside {CFG_PL, CFG_PH, CFG_CTL, STOP_CTL, SNAP_WR, IRQ_CLR});
        addr_d = ADDR_STATUS;
        wd_d   = '0;
        case (state_d)
            CFG_PL:            begin addr_d = ADDR_PERIODL; wd_d = period_d[15:0]; end
            CFG_PH:            begin addr_d = ADDR_PERIODH; wd_d = period_d[31:16]; end
            CFG_CTL:           begin addr_d = ADDR_CONTROL; wd_d = ctrl_word(1'b0, 1'b1, cont_d, ien_d); end
            STOP_CTL:          begin addr_d = ADDR_CONTROL; wd_d = ctrl_word(1'b1, 1'b0, cont_d, ien_d); end
            SNAP_WR, SNAP_RL:  addr_d = ADDR_SNAPL;
            SNAP_RH, SNAP_CAP: addr_d = ADDR_SNAPH;
            default:           addr_d = ADDR_STATUS;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            period_q     <= '0;
            cont_q       <= 1'b0;
            ien_q        <= 1'b0;
            snap_lo_q    <= '0;
            resp_data_q  <= '0;
            done_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            tick_q       <= 1'b0;
            tick_count_q <= '0;
            addr_q       <= ADDR_STATUS;
            cs_q         <= 1'b0;
            wn_q         <= 1'b1;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            cont_q       <= cont_d;
            ien_q        <= ien_d;
            snap_lo_q    <= snap_lo_d;
            resp_data_q  <= resp_data_d;
            done_q       <= done_d;
            resp_valid_q <= resp_valid_d;
            tick_q       <= tick_d;
            tick_count_q <= tick_count_d;
            addr_q       <= addr_d;
            cs_q         <= cs_d;
            wn_q         <= wn_d;
            wd_q         <= wd_d;
        end
    end

    assign done          = done_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign tick          = tick_q;
    assign tick_count    = tick_count_q;
    assign av.address    = addr_q;
    assign av.chipselect = cs_q;
    assign av.write_n    = wn_q;
    assign av.writedata  = wd_q;

endmodule

// File: tb/tb_timer_ctrl_master.sv
// tb_timer_ctrl_master: randomized command/interrupt traffic against a behavioural timer and command-sequence model.
module tb_timer_ctrl_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_continuous, cmd_irq_en;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_period;
    logic        done, resp_valid, tick;
    logic [31:0] resp_data;
    logic [15:0] tick_count;

    logic [31:0] counter, snap;
    logic        fire;
    logic        lc, li;
    int          exp_ticks, n_chk, n_pass;
    logic [31:0] exp_resp;

    localparam logic [22:0] IDLE_W = {2'b01, 3'd0, 16'h0};

    timer_ctrl_master_if bus ();

    timer_ctrl_master #(.TICK_W(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_period     (cmd_period),
        .cmd_continuous (cmd_continuous),
        .cmd_irq_en     (cmd_irq_en),
        .done           (done),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .tick           (tick),
        .tick_count     (tick_count),
        .av             (bus)
    );

    always #5 clk = ~clk;

    // Timer peripheral: status write clears the interrupt (clear wins), snapshot on SNAPL/SNAPH write, 1-cycle read latency
    always @(posedge clk) begin
        if (!reset_n) bus.irq <= 1'b0;
        else bus.irq <= (bus.chipselect && !bus.write_n && bus.address == 3'd0) ? 1'b0 : (fire ? 1'b1 : bus.irq);
        if (bus.chipselect && !bus.write_n && (bus.address == 3'd4 || bus.address == 3'd5)) snap <= counter;
        if (bus.chipselect && bus.write_n) bus.readdata <= bus.address == 3'd5 ? snap[31:16] : snap[15:0];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [22:0] bus_obs();
        logic ign;
        ign = bus.write_n || bus.address == 3'd4;
        return {bus.chipselect, bus.write_n, bus.address, ign ? 16'h0 : bus.writedata};
    endfunction

    function automatic logic [22:0] bw(input logic [2:0] a, input logic [15:0] d);
        return {2'b10, a, d};
    endfunction

    function automatic logic [22:0] br(input logic [2:0] a);
        return {2'b11, a, 16'h0};
    endfunction

    function automatic logic [15:0] ctl_bits(input logic c, input logic i);
        return (c ? 16'h2 : 16'h0) | (i ? 16'h1 : 16'h0);
    endfunction

    // For SNAP the p argument is the timer counter value to be snapshotted
    task automatic do_cmd(input logic [1:0] op, input logic [31:0] p, input logic c, input logic i, input bit b2b);
        logic [22:0] exp_q[$];
        case (op)
            2'd0: exp_q = {bw(3'd2, p[15:0]), bw(3'd3, p[31:16]), bw(3'd1, 16'h4 | ctl_bits(c, i))};
            2'd1: exp_q = {bw(3'd1, 16'h8 | ctl_bits(lc, li))};
            2'd2: exp_q = {bw(3'd4, 16'h0), br(3'd4), br(3'd5), br(3'd5)};
            default: exp_q = {};
        endcase
        if (!b2b) @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_period = p; cmd_continuous = c; cmd_irq_en = i;
        if (op == 2'd2) counter = p;
        chk("cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        foreach (exp_q[k]) begin
            chk("bus_seq", 32'(bus_obs()), 32'(exp_q[k]));
            chk("done_early", 32'(done), 32'd0);
            @(negedge clk);
        end
        chk("bus_end", 32'(bus_obs()), 32'(IDLE_W));
        chk("done", 32'(done), 32'd1);
        chk("resp_valid", 32'(resp_valid), 32'(op == 2'd2));
        if (op == 2'd2) exp_resp = p;
        chk("resp_data", resp_data, exp_resp);
        if (op == 2'd0) begin lc = c; li = i; end
    endtask

    task automatic do_irq();
        @(negedge clk); fire = 1'b1;
        @(negedge clk); fire = 1'b0;
        chk("irq_ready_low", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("irq_clr_bus", 32'(bus_obs()), 32'(bw(3'd0, 16'h0)));
        chk("irq_tick_early", 32'(tick), 32'd0);
        chk("irq_ready_low2", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        exp_ticks = (exp_ticks + 1) % 65536;
        chk("tick", 32'(tick), 32'd1);
        chk("tick_count", 32'(tick_count), 32'(exp_ticks));
        chk("irq_bus_idle", 32'(bus_obs()), 32'(IDLE_W));
        chk("irq_ready_back", 32'(cmd_ready), 32'd1);
    endtask

    task automatic do_irq_stop();
        @(negedge clk); fire = 1'b1;
        @(negedge clk); fire = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'd1;
        chk("arb_ready_low", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("arb_clr_first", 32'(bus_obs()), 32'(bw(3'd0, 16'h0)));
        chk("arb_done1", 32'(done), 32'd0);
        @(negedge clk);
        exp_ticks = (exp_ticks + 1) % 65536;
        chk("arb_tick", 32'(tick), 32'd1);
        chk("arb_tick_count", 32'(tick_count), 32'(exp_ticks));
        chk("arb_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("arb_stop_bus", 32'(bus_obs()), 32'(bw(3'd1, 16'h8 | ctl_bits(lc, li))));
        chk("arb_done3", 32'(done), 32'd0);
        @(negedge clk);
        chk("arb_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("arb_single_done", 32'(done), 32'd0);
    endtask

    task automatic do_reset_mid();
        logic [31:0] p;
        p = $urandom;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_period = p; cmd_continuous = 1'b1; cmd_irq_en = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_cfg_ph", 32'(bus_obs()), 32'(bw(3'd3, p[31:16])));
        #1 reset_n = 1'b0;
        #1;
        chk("rst_bus_idle", 32'(bus_obs()), 32'(IDLE_W));
        chk("rst_ready_low", 32'(cmd_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        lc = 1'b0; li = 1'b0; exp_ticks = 0; exp_resp = '0;
        chk("rst_tick_count", 32'(tick_count), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_no_done", 32'(done), 32'd0);
            chk("rst_bus_quiet", 32'(bus_obs()), 32'(IDLE_W));
        end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_op = 2'd3; cmd_period = '0; cmd_continuous = 1'b0; cmd_irq_en = 1'b0;
        fire = 1'b0; counter = '0;
        lc = 1'b0; li = 1'b0; exp_ticks = 0; exp_resp = '0; n_chk = 0; n_pass = 0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(cmd_ready), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_resp_data", resp_data, 32'd0);
        chk("reset_tick", 32'(tick), 32'd0);
        chk("reset_tick_count", 32'(tick_count), 32'd0);
        chk("reset_bus", 32'(bus_obs()), 32'(IDLE_W));
        reset_n = 1'b1;
        #1;
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        do_cmd(2'd0, 32'h0001_86A0, 1'b1, 1'b1, 1'b0);
        do_cmd(2'd2, 32'h0002_1234, 1'b0, 1'b0, 1'b1);
        do_cmd(2'd3, 32'h0, 1'b0, 1'b0, 1'b1);
        do_irq();
        do_irq_stop();
        do_reset_mid();
        do_cmd(2'd0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        do_cmd(2'd1, 32'h0, 1'b0, 1'b0, 1'b1);

        @(negedge clk);
        force dut.tick_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.tick_count_q;
        exp_ticks = 65535;
        chk("wrap_preset", 32'(tick_count), 32'hFFFF);
        do_irq();

        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) < 2) do_irq();
            else do_cmd(2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
